// File: rtl/mem_stage_wb.sv
// MEM stage fused with the MEM/WB pipeline register.
// Holds the word-addressed data memory, resolves the branch decision and
// registers the writeback bundle (control, read data, ALU result, Rd index).
module mem_stage_wb #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 256,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  MemToReg_in,
    input  logic                  RegWrite_in,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic                  Branch,
    input  logic                  Is_Zero,
    input  logic [DATA_WIDTH-1:0] ALU_Result_in,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic [REG_ADDR_W-1:0] RegisterRd_in,
    input  logic [DATA_WIDTH-1:0] PC_Branch_in,
    output logic                  PCSrc,
    output logic [DATA_WIDTH-1:0] PC_Branch_out,
    output logic                  MemToReg_out,
    output logic                  RegWrite_out,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic [DATA_WIDTH-1:0] ALU_Result_out,
    output logic [REG_ADDR_W-1:0] RegisterRd_out
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    // Byte address -> word index; low two bits and bits above the depth are dropped,
    // so misaligned addresses hit the containing word and large addresses wrap.
    logic [IDX_W-1:0]      wordIdx;
    logic [DATA_WIDTH-1:0] readData;

    // NOTE: the data memory is deliberately left out of the reset; it is only
    // zeroed at power-up so that stored data survives a pipeline reset and the
    // array can map onto a RAM macro without per-word reset logic.
    logic [DATA_WIDTH-1:0] dataMem [MEM_WORDS] = '{default: '0};

    assign wordIdx = ALU_Result_in[IDX_W+1:2];

    // Branch is taken only for a branch instruction whose compare produced zero.
    assign PCSrc         = Branch & Is_Zero;
    assign PC_Branch_out = PC_Branch_in;

    // Combinational read, gated so an idle stage presents zero to writeback.
    assign readData = MemRead ? dataMem[wordIdx] : '0;

    // Synchronous store; suppressed while reset is held.
    always_ff @(posedge clock) begin
        if (MemWrite && !reset) begin
            dataMem[wordIdx] <= WriteData;
        end
    end

    // MEM/WB register: loads every cycle, cleared asynchronously by reset.
    // NOTE: non-blocking assignment here and in the store above means a load and a
    // store to the same word on one edge both see the pre-write contents.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            MemToReg_out   <= 1'b0;
            RegWrite_out   <= 1'b0;
            ReadData       <= '0;
            ALU_Result_out <= '0;
            RegisterRd_out <= '0;
        end else begin
            MemToReg_out   <= MemToReg_in;
            RegWrite_out   <= RegWrite_in;
            ReadData       <= readData;
            ALU_Result_out <= ALU_Result_in;
            RegisterRd_out <= RegisterRd_in;
        end
    end

endmodule

// File: tb/tb_mem_stage_wb.sv
// Self-checking bench for mem_stage_wb: directed tables, hand-written corner
// sequences and randomized traffic against a word-array reference model.
module tb_mem_stage_wb;

    localparam int DW = 32;
    localparam int MW = 256;
    localparam int RW = 5;

    logic          clock = 1'b0;
    logic          reset;
    logic          MemToReg_in, RegWrite_in, MemWrite, MemRead, Branch, Is_Zero;
    logic [DW-1:0] ALU_Result_in, WriteData, PC_Branch_in;
    logic [RW-1:0] RegisterRd_in;
    logic          PCSrc, MemToReg_out, RegWrite_out;
    logic [DW-1:0] PC_Branch_out, ReadData, ALU_Result_out;
    logic [RW-1:0] RegisterRd_out;

    int checks = 0;
    int errors = 0;

    // Reference memory: one entry per word, indexed by byte address / 4 modulo depth.
    logic [DW-1:0] modelMem [MW];

    always #5 clock = ~clock;

    mem_stage_wb #(.DATA_WIDTH(DW), .MEM_WORDS(MW), .REG_ADDR_W(RW)) dut (
        .clock         (clock),
        .reset         (reset),
        .MemToReg_in   (MemToReg_in),
        .RegWrite_in   (RegWrite_in),
        .MemWrite      (MemWrite),
        .MemRead       (MemRead),
        .Branch        (Branch),
        .Is_Zero       (Is_Zero),
        .ALU_Result_in (ALU_Result_in),
        .WriteData     (WriteData),
        .RegisterRd_in (RegisterRd_in),
        .PC_Branch_in  (PC_Branch_in),
        .PCSrc         (PCSrc),
        .PC_Branch_out (PC_Branch_out),
        .MemToReg_out  (MemToReg_out),
        .RegWrite_out  (RegWrite_out),
        .ReadData      (ReadData),
        .ALU_Result_out(ALU_Result_out),
        .RegisterRd_out(RegisterRd_out)
    );

    typedef struct {
        logic        branch;
        logic        isZero;
        logic        expPcSrc;
    } branch_vec_t;

    typedef struct {
        logic        memWrite;
        logic        memRead;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRead;
    } mem_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, " MemToReg_out"},   32'(MemToReg_out),   32'h0);
        check({tag, " RegWrite_out"},   32'(RegWrite_out),   32'h0);
        check({tag, " ReadData"},       ReadData,            32'h0);
        check({tag, " ALU_Result_out"}, ALU_Result_out,      32'h0);
        check({tag, " RegisterRd_out"}, 32'(RegisterRd_out), 32'h0);
    endtask

    // Predict the MEM/WB contents from the current inputs, advance one edge,
    // compare, and apply any store to the reference memory.
    task automatic doCycle(input string tag);
        int            idx;
        logic [31:0]   expRead;
        logic          expM2r, expRw;
        logic [31:0]   expAlu;
        logic [RW-1:0] expRd;
        idx     = int'((ALU_Result_in / 4) % MW);
        expRead = MemRead ? modelMem[idx] : 32'h0;
        expM2r  = MemToReg_in;
        expRw   = RegWrite_in;
        expAlu  = ALU_Result_in;
        expRd   = RegisterRd_in;
        if (MemWrite) modelMem[idx] = WriteData;
        @(posedge clock);
        #1;
        check({tag, " MemToReg_out"},   32'(MemToReg_out),   32'(expM2r));
        check({tag, " RegWrite_out"},   32'(RegWrite_out),   32'(expRw));
        check({tag, " ReadData"},       ReadData,            expRead);
        check({tag, " ALU_Result_out"}, ALU_Result_out,      expAlu);
        check({tag, " RegisterRd_out"}, 32'(RegisterRd_out), 32'(expRd));
    endtask

    branch_vec_t brTab [4];
    mem_vec_t    memTab [9];

    initial begin
        for (int i = 0; i < MW; i++) modelMem[i] = '0;

        brTab[0] = '{1'b0, 1'b0, 1'b0};
        brTab[1] = '{1'b1, 1'b0, 1'b0};
        brTab[2] = '{1'b0, 1'b1, 1'b0};
        brTab[3] = '{1'b1, 1'b1, 1'b1};

        memTab[0] = '{1'b1, 1'b0, 32'd0, 32'h0000FFFF, 32'h0};
        memTab[1] = '{1'b1, 1'b0, 32'd4, 32'h0000EEEE, 32'h0};
        memTab[2] = '{1'b1, 1'b0, 32'd8, 32'h0000DDDD, 32'h0};
        memTab[3] = '{1'b0, 1'b1, 32'd0, 32'h0,        32'h0000FFFF};
        memTab[4] = '{1'b0, 1'b1, 32'd4, 32'h0,        32'h0000EEEE};
        memTab[5] = '{1'b0, 1'b1, 32'd8, 32'h0,        32'h0000DDDD};
        memTab[6] = '{1'b0, 1'b0, 32'd4, 32'h0,        32'h0};
        memTab[7] = '{1'b1, 1'b1, 32'd4, 32'h00001234, 32'h0000EEEE};
        memTab[8] = '{1'b0, 1'b1, 32'd4, 32'h0,        32'h00001234};

        // Reset with arbitrary inputs; a store attempted under reset must be dropped.
        reset         = 1'b0;
        MemToReg_in   = 1'b1;
        RegWrite_in   = 1'b1;
        MemWrite      = 1'b1;
        MemRead       = 1'b1;
        Branch        = 1'b0;
        Is_Zero       = 1'b0;
        ALU_Result_in = 32'd12;
        WriteData     = 32'hA5A5A5A5;
        RegisterRd_in = 5'd7;
        PC_Branch_in  = 32'h0;
        #1 reset = 1'b1;
        #1;
        checkAllZero("reset_immediate");
        @(posedge clock); #1;
        @(posedge clock); #1;
        checkAllZero("reset_held");

        // Release, then the first edge loads; word 3 must still be zero.
        @(negedge clock);
        reset         = 1'b0;
        MemWrite      = 1'b0;
        MemToReg_in   = 1'b0;
        RegisterRd_in = 5'd3;
        doCycle("reset_release");

        // Branch resolution is purely combinational.
        PC_Branch_in = 32'h0000FFFF;
        foreach (brTab[i]) begin
            Branch  = brTab[i].branch;
            Is_Zero = brTab[i].isZero;
            #1;
            check($sformatf("branch%0d PCSrc", i), 32'(PCSrc), 32'(brTab[i].expPcSrc));
            check($sformatf("branch%0d PC_Branch_out", i), PC_Branch_out, 32'h0000FFFF);
        end

        // Store / load / gating / read-during-write table.
        MemToReg_in   = 1'b0;
        RegWrite_in   = 1'b0;
        RegisterRd_in = 5'd0;
        foreach (memTab[i]) begin
            MemWrite      = memTab[i].memWrite;
            MemRead       = memTab[i].memRead;
            ALU_Result_in = memTab[i].addr;
            WriteData     = memTab[i].wdata;
            doCycle($sformatf("memvec%0d", i));
            check($sformatf("memvec%0d table ReadData", i), ReadData, memTab[i].expRead);
        end

        // Passthrough: new values must not appear before the edge.
        MemWrite      = 1'b0;
        MemRead       = 1'b0;
        ALU_Result_in = 32'd0;
        doCycle("pass_prep");
        RegisterRd_in = 5'h1F;
        RegWrite_in   = 1'b1;
        MemToReg_in   = 1'b1;
        ALU_Result_in = 32'h8;
        #2;
        check("pass_before RegisterRd_out", 32'(RegisterRd_out), 32'h0);
        check("pass_before RegWrite_out",   32'(RegWrite_out),   32'h0);
        check("pass_before ALU_Result_out", ALU_Result_out,      32'h0);
        doCycle("pass_after");
        check("pass_after table RegisterRd_out", 32'(RegisterRd_out), 32'h1F);

        // Address wrap and misaligned access.
        MemRead       = 1'b1;
        ALU_Result_in = 32'(4 * MW);
        doCycle("wrap");
        check("wrap table ReadData", ReadData, 32'h0000FFFF);
        ALU_Result_in = 32'd9;
        doCycle("misaligned");
        check("misaligned table ReadData", ReadData, 32'h0000DDDD);

        // Asynchronous reset between edges clears the register at once.
        @(posedge clock); #2;
        reset = 1'b1;
        #1;
        checkAllZero("async_mid");
        @(posedge clock); #1;
        checkAllZero("async_held");
        @(negedge clock);
        reset = 1'b0;
        doCycle("async_release");

        // Randomized traffic against the reference model, including wrapping addresses.
        for (int n = 0; n < 400; n++) begin
            MemToReg_in   = 1'($urandom_range(0, 1));
            RegWrite_in   = 1'($urandom_range(0, 1));
            MemWrite      = 1'($urandom_range(0, 1));
            MemRead       = 1'($urandom_range(0, 1));
            Branch        = 1'($urandom_range(0, 1));
            Is_Zero       = 1'($urandom_range(0, 1));
            ALU_Result_in = (n % 4 == 0) ? $urandom : 32'($urandom_range(0, 8 * MW - 1));
            WriteData     = $urandom;
            RegisterRd_in = 5'($urandom);
            PC_Branch_in  = $urandom;
            #1;
            check("rand PCSrc", 32'(PCSrc), 32'(Branch && Is_Zero));
            check("rand PC_Branch_out", PC_Branch_out, PC_Branch_in);
            doCycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
